// File: rtl/seq_divider_4.sv
// Restoring unsigned divider: one quotient bit per clock, results and done pulse WIDTH cycles after start is accepted.
// No backpressure; start is only sampled while idle, so a busy request is dropped and must be re-issued.
module seq_divider_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // One extra bit lets the trial-subtraction sign be taken straight from the MSB.
  logic [WIDTH+1:0] a_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    a_sh    = {a_q, q_q[WIDTH-1]};
    trial   = a_sh - {2'b00, d_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        if (!trial[WIDTH+1]) begin
          a_d = trial[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          a_d = a_sh[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          quot_d  = q_d;
          rem_d   = a_d[WIDTH-1:0];
          dbz_d   = (d_q == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4.sv
// Bench for seq_divider_4: directed scenarios plus exhaustive and random operands against an arithmetic model.
module tb_seq_divider_4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Last result the model expects the DUT to be holding.
  int last_q = 0;
  int last_r = 0;
  int last_z = 0;

  seq_divider_4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input int x, input int y, output int q, output int r, output int z);
    if (y == 0) begin
      q = (1 << W) - 1;
      r = x;
      z = 1;
    end else begin
      q = x / y;
      r = x % y;
      z = 0;
    end
  endfunction

  // Called one time unit after a rising edge; returns cycles from accept to done (99 = never).
  task automatic run_op(input int x, input int y, output int cyc);
    dividend = x[W-1:0];
    divisor  = y[W-1:0];
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    int seen;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(13, 3, cyc);
    n_checks++;
    if (cyc != 4 || quotient !== 4'd4 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_pre_op cyc=%0d q=%0d r=%0d want cyc=4 q=4 r=1", cyc, quotient, remainder);
    end
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_midrun got=%b want=0", {busy, done, quotient, remainder, div_by_zero});
    end
    #3 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_no_done got activity=%0d want 0", seen);
    end
    run_op(13, 3, cyc);
    n_checks++;
    if (cyc != 4 || quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fresh_op cyc=%0d q=%0d r=%0d z=%0d want 4/4/1/0", cyc, quotient, remainder, div_by_zero);
    end
    last_q = 4; last_r = 1; last_z = 0;
  endtask

  task automatic test_basic();
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy step=%0d busy=%b done=%b want busy=1 done=0", k, busy, done);
      end
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b01 || quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done busy=%b done=%b q=%0d r=%0d z=%b want 0/1/4/1/0", busy, done, quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00 || quotient !== 4'd4 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_after busy=%b done=%b q=%0d r=%0d want 0/0/4/1", busy, done, quotient, remainder);
    end
    last_q = 4; last_r = 1; last_z = 0;
  endtask

  task automatic test_boundaries();
    int xs[6] = '{15, 2, 0, 15, 7, 8};
    int ys[6] = '{1, 9, 5, 15, 0, 2};
    int cyc, eq, er, ez;
    for (int i = 0; i < 6; i++) begin
      model(xs[i], ys[i], eq, er, ez);
      run_op(xs[i], ys[i], cyc);
      n_checks++;
      if (cyc != 4 || quotient !== eq[W-1:0] || remainder !== er[W-1:0] || div_by_zero !== ez[0]) begin
        n_fail++;
        $display("FAIL boundary %0d/%0d cyc=%0d q=%0d r=%0d z=%b want cyc=4 q=%0d r=%0d z=%0d",
                 xs[i], ys[i], cyc, quotient, remainder, div_by_zero, eq, er, ez);
      end
      last_q = eq; last_r = er; last_z = ez;
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 99;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
    n_checks++;
    if (cyc != 2 || quotient !== 4'd4 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL busy_ignore cyc=%0d q=%0d r=%0d want cyc=2 q=4 r=1", cyc, quotient, remainder);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore_idle busy=%b want 0", busy);
    end
    last_q = 4; last_r = 1; last_z = 0;
  endtask

  task automatic test_back_to_back();
    int xs[3] = '{13, 14, 6};
    int ys[3] = '{3, 4, 6};
    int eq, er, ez, gap;
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      model(xs[i], ys[i], eq, er, ez);
      gap = 99;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (done) begin
          gap = k;
          break;
        end
        n_checks++;
        if (quotient !== last_q[W-1:0] || remainder !== last_r[W-1:0] || div_by_zero !== last_z[0]) begin
          n_fail++;
          $display("FAIL b2b_hold op=%0d q=%0d r=%0d z=%b want %0d/%0d/%0d", i, quotient, remainder, div_by_zero, last_q, last_r, last_z);
        end
      end
      n_checks++;
      if (gap != ((i == 0) ? 4 : 5) || quotient !== eq[W-1:0] || remainder !== er[W-1:0] || div_by_zero !== ez[0]) begin
        n_fail++;
        $display("FAIL b2b_op op=%0d gap=%0d q=%0d r=%0d want gap=%0d q=%0d r=%0d", i, gap, quotient, remainder, (i == 0) ? 4 : 5, eq, er);
      end
      last_q = eq; last_r = er; last_z = ez;
      if (i < 2) begin
        dividend = xs[i+1][W-1:0];
        divisor  = ys[i+1][W-1:0];
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_stop busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_exhaustive();
    int cyc, eq, er, ez;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        model(x, y, eq, er, ez);
        run_op(x, y, cyc);
        n_checks++;
        if (cyc != 4 || quotient !== eq[W-1:0] || remainder !== er[W-1:0] || div_by_zero !== ez[0]) begin
          n_fail++;
          $display("FAIL exhaustive %0d/%0d cyc=%0d q=%0d r=%0d z=%b want 4 %0d %0d %0d", x, y, cyc, quotient, remainder, div_by_zero, eq, er, ez);
        end
        if (y != 0) begin
          n_checks++;
          if (int'(quotient) * y + int'(remainder) != x || int'(remainder) >= y) begin
            n_fail++;
            $display("FAIL invariant %0d/%0d q=%0d r=%0d", x, y, quotient, remainder);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int x, y, cyc, eq, er, ez;
    for (int i = 0; i < 60; i++) begin
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      model(x, y, eq, er, ez);
      run_op(x, y, cyc);
      n_checks++;
      if (cyc != 4 || quotient !== eq[W-1:0] || remainder !== er[W-1:0] || div_by_zero !== ez[0]) begin
        n_fail++;
        $display("FAIL random %0d/%0d cyc=%0d q=%0d r=%0d z=%b want 4 %0d %0d %0d", x, y, cyc, quotient, remainder, div_by_zero, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_busy_ignore();
    test_back_to_back();
    test_exhaustive();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/seq_divider_4.md
Name: seq_divider_4

Overview:
- Sequential unsigned restoring divider; arithmetic inverse of the team's 4x4 array multiplier.
- Accepts dividend/divisor on a start pulse and produces quotient and remainder after WIDTH iterations, one quotient bit per clock.
- Sits beside the multiplier in the datapath (DIV/REM support); a start/busy/done handshake lets a controller sequence it.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- dividend  input  WIDTH  unsigned dividend, captured when start is accepted
- divisor  input  WIDTH  unsigned divisor, captured when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  unsigned quotient, held until next accepted start
- remainder  output  WIDTH  unsigned remainder, held until next accepted start
- div_by_zero  output  1  set with done when captured divisor == 0; held with results

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: waits for start.
  - RUN: performs the iterations.
- IDLE -> RUN on rising edge N with start=1:
  - capture dividend into the Q shift register, divisor into the D register, and zero into the A (partial remainder, WIDTH+1 bits) register;
  - count = WIDTH; busy=1 after edge N; done=0.
- RUN, each edge N+1..N+WIDTH:
  - shift {A,Q} left by 1;
  - trial T = A - {0,D} (WIDTH+1 bits);
  - if T is non-negative (MSB=0), A=T and Q[0]=1; else A unchanged and Q[0]=0;
  - count decrements.
- RUN -> IDLE on edge N+WIDTH (last iteration):
  - quotient=Q, remainder=A[WIDTH-1:0], div_by_zero=(D==0);
  - done=1 and busy=0 for exactly the cycle following edge N+WIDTH.
- Latency: start accepted at edge N, done and results visible after edge N+WIDTH (WIDTH cycles). Throughput is one operation per WIDTH+1 cycles minimum.
- start while busy=1 is ignored: no capture and no effect on the in-flight operation.
- start high in the done cycle is accepted; done still deasserts at the next edge and busy rises.
- start held high continuously yields back-to-back operations, each producing its own done pulse.
- quotient, remainder and div_by_zero are updated only at RUN -> IDLE. They are stable during a subsequent RUN and change only at the next completion or on reset.
- Divide by zero needs no special path:
  - the algorithm yields quotient = all ones and remainder = dividend;
  - div_by_zero=1;
  - latency is unchanged.
- Invariant for divisor != 0: dividend == quotient*divisor + remainder, with remainder < divisor.

Test Plan:
- Reset: drive rst=1 mid-RUN (after 2 iterations of 13/3) -> busy=0, done=0, all outputs 0 immediately; no done pulse follows. After release, a fresh 13/3 completes normally.
- Basic: start with dividend=13, divisor=3 at edge N -> busy=1 for edges N+1..N+4; after edge N+4, done=1 for one cycle, quotient=4, remainder=1, div_by_zero=0.
- Boundaries:
  - 15/1 -> q=15, r=0;
  - 2/9 -> q=0, r=2;
  - 0/5 -> q=0, r=0;
  - 15/15 -> q=1, r=0.
- Divide by zero: 7/0 -> after 4 cycles q=15, r=7, div_by_zero=1. A following 8/2 -> q=4, r=0, div_by_zero=0.
- Handshake:
  - start pulsed with 9/2 while busy -> ignored, and the in-flight 13/3 result is 4 r1;
  - start held high for 3 operations (13/3, 14/4, 6/6, changing operands in each done cycle) -> three done pulses spaced 5 cycles apart with results 4r1, 3r2, 1r0;
  - outputs hold between done pulses.
- Exhaustive: all 256 operand pairs for WIDTH=4 checked against the invariant and against the reference model (x/y, x%y; 15 and x for y=0).
